// File: rtl/unaligned_access_sequencer_pkg.sv
// Shared encodings for the unaligned access sequencer: FSM states, access sizes
// and the byte-keep mask used to truncate load results.
package unaligned_access_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        RESP   = 2'd3
    } uas_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Reserved size 3 falls through to a full word.
    function automatic logic [31:0] size_keep(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 32'h0000_00FF;
            SIZE_HALF: return 32'h0000_FFFF;
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/unaligned_access_sequencer_lane_mask.sv
// Maps access size and byte offset to an 8-lane enable mask spanning two
// aligned words, plus a flag saying the upper word is touched.
module uas_lane_mask
    import unaligned_access_sequencer_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] off,
    output logic [7:0] mask,
    output logic       split
);

    logic [7:0] base;

    always_comb begin
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            default:   base = 8'h0F;
        endcase
        mask  = base << off;
        split = |mask[7:4];
    end

endmodule

// File: rtl/unaligned_access_sequencer.sv
// Splits CPU loads/stores of any alignment into one or two word-aligned memory
// accesses. Define UNALIGNED_SIGN_EXT_EN to add req_signed for sign-extended loads.
module unaligned_access_sequencer
    import unaligned_access_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
`ifdef UNALIGNED_SIGN_EXT_EN
    input  logic                  req_signed,
`endif
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byteen,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata
);

    uas_state_t            state, state_nxt;
    logic                  r_write;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           rd_lo, rd_hi;
`ifdef UNALIGNED_SIGN_EXT_EN
    logic                  r_signed;
`endif

    logic [1:0]            off;
    logic [7:0]            mask;
    logic                  split;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [63:0]           wide_wdata;
    logic [63:0]           rd_shift;
    logic [31:0]           load_res;

    assign off       = r_addr[1:0];
    assign base_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    uas_lane_mask u_mask (
        .size  (r_size),
        .off   (off),
        .mask  (mask),
        .split (split)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = FIRST;
            FIRST:   if (mem_ready) state_nxt = split ? SECOND : RESP;
            SECOND:  if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and read-data capture; rd_hi is cleared so unsplit loads
    // never merge stale upper-word data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_addr   <= '0;
            r_wdata  <= '0;
            rd_lo    <= '0;
            rd_hi    <= '0;
`ifdef UNALIGNED_SIGN_EXT_EN
            r_signed <= 1'b0;
`endif
        end else begin
            if (state == IDLE && req_valid) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                rd_lo    <= '0;
                rd_hi    <= '0;
`ifdef UNALIGNED_SIGN_EXT_EN
                r_signed <= req_signed;
`endif
            end
            if (state == FIRST && mem_ready)  rd_lo <= mem_rdata;
            if (state == SECOND && mem_ready) rd_hi <= mem_rdata;
        end
    end

    always_comb begin
        wide_wdata = {32'b0, r_wdata} << {off, 3'b000};
        rd_shift   = {rd_hi, rd_lo} >> {off, 3'b000};
        load_res   = rd_shift[31:0] & size_keep(r_size);
`ifdef UNALIGNED_SIGN_EXT_EN
        if (r_signed) begin
            case (r_size)
                SIZE_BYTE: load_res = {{24{rd_shift[7]}}, rd_shift[7:0]};
                SIZE_HALF: load_res = {{16{rd_shift[15]}}, rd_shift[15:0]};
                default:   load_res = rd_shift[31:0];
            endcase
        end
`endif
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_byteen = 4'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        case (state)
            IDLE: req_ready = 1'b1;
            FIRST: begin
                mem_valid  = 1'b1;
                mem_write  = r_write;
                mem_addr   = base_addr;
                mem_byteen = mask[3:0];
                mem_wdata  = r_write ? wide_wdata[31:0] : 32'h0;
            end
            SECOND: begin
                mem_valid  = 1'b1;
                mem_write  = r_write;
                mem_addr   = base_addr + ADDR_WIDTH'(4);
                mem_byteen = mask[7:4];
                mem_wdata  = r_write ? wide_wdata[63:32] : 32'h0;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_write ? 32'h0 : load_res;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unaligned_access_sequencer.sv
// Scoreboard bench: each request pushes its expected memory accesses and response;
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_unaligned_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_signed = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    unaligned_access_sequencer #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef UNALIGNED_SIGN_EXT_EN
        .req_signed (req_signed),
`endif
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    acc_t aq[$];
    rsp_t rq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sits 1 time unit past the negedge so bench drives at the negedge are settled.
    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        #1;
        if (!reset) begin
            if (mem_valid && mem_ready) begin
                if (aq.size() == 0) chk("acc_spurious", mem_valid, 1'b0);
                else begin
                    e = aq.pop_front();
                    chk("mem_addr", mem_addr, e.a);
                    chk("mem_byteen", mem_byteen, e.be);
                    chk("mem_write", mem_write, e.wr);
                    if (e.wr) chk("mem_wdata", mem_wdata & lanes(e.be), e.wd);
                    mem_rdata = e.rd;
                end
            end else if (mem_valid && aq.size() != 0) begin
                chk("stall_addr", mem_addr, aq[0].a);
                chk("stall_byteen", mem_byteen, aq[0].be);
            end
            if (resp_valid) begin
                if (rq.size() == 0) chk("resp_spurious", resp_valid, 1'b0);
                else begin
                    r = rq.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_cycle", cyc, r.due);
                end
            end
        end
    end

    task automatic send(input string tag, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic sg,
                        input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                        input logic [31:0] rd0, input logic spl, input logic [31:0] a1,
                        input logic [3:0] be1, input logic [31:0] wd1, input logic [31:0] rd1,
                        input logic [31:0] exp_rd);
        int k;
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_addr   = a;
        req_wdata  = wd;
        req_signed = sg;
        aq.push_back('{a: a0, be: be0, wr: wr, wd: wd0, rd: rd0});
        if (spl) aq.push_back('{a: a1, be: be1, wr: wr, wd: wd1, rd: rd1});
        rq.push_back('{rdata: exp_rd, due: cyc + (spl ? 3 : 2)});
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (rq.size() != 0 && k < 40) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk({tag, "_resp_seen"}, rq.size(), 0);
        chk({tag, "_acc_left"}, aq.size(), 0);
        rq.delete();
        aq.delete();
    endtask

    initial begin
        logic [31:0] exp_sb;
        exp_sb = 32'h0000_0080;
`ifdef UNALIGNED_SIGN_EXT_EN
        exp_sb = 32'hFFFF_FF80;
`endif
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_byteen", mem_byteen, 4'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_req_ready", req_ready, 1'b1);

        //   tag         wr sz    addr          wdata         sg  a0            be0   wd0           rd0           spl a1            be1   wd1           rd1           exp
        send("ld_w_al",  0, 2'd2, 32'h0000_1000, 32'h0,       0, 32'h0000_1000, 4'hF, 32'h0,        32'hAABB_CCDD, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'hAABB_CCDD);
        send("ld_w_spl", 0, 2'd2, 32'h0000_1002, 32'h0,       0, 32'h0000_1000, 4'hC, 32'h0,        32'h4433_2211, 1, 32'h0000_1004, 4'h3, 32'h0,        32'h8877_6655, 32'h6655_4433);
        send("st_h_spl", 1, 2'd1, 32'h0000_2003, 32'hBEEF,    0, 32'h0000_2000, 4'h8, 32'hEF00_0000, 32'hFFFF_FFFF, 1, 32'h0000_2004, 4'h1, 32'h0000_00BE, 32'hFFFF_FFFF, 32'h0);
        send("ld_h_wrap",0, 2'd1, 32'hFFFF_FFFF, 32'h0,       0, 32'hFFFF_FFFC, 4'h8, 32'h0,        32'hA500_0000, 1, 32'h0000_0000, 4'h1, 32'h0,        32'h0000_005A, 32'h0000_5AA5);
        send("ld_b_sgn", 0, 2'd0, 32'h0000_3001, 32'h0,       1, 32'h0000_3000, 4'h2, 32'h0,        32'h0000_8000, 0, 32'h0,        4'h0, 32'h0,        32'h0,        exp_sb);
        send("ld_h_mid", 0, 2'd1, 32'h0000_4001, 32'h0,       0, 32'h0000_4000, 4'h6, 32'h0,        32'h00CA_FE00, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0000_CAFE);
        send("st_b_top", 1, 2'd0, 32'h0000_5003, 32'h1234_56AB, 0, 32'h0000_5000, 4'h8, 32'hAB00_0000, 32'hDEAD_BEEF, 0, 32'h0,      4'h0, 32'h0,        32'h0,        32'h0);
        send("st_w_spl", 1, 2'd2, 32'h0000_6001, 32'h1122_3344, 0, 32'h0000_6000, 4'hE, 32'h2233_4400, 32'h0,      1, 32'h0000_6004, 4'h1, 32'h0000_0011, 32'h0,        32'h0);
        send("ld_rsvd",  0, 2'd3, 32'h0000_7000, 32'h0,       0, 32'h0000_7000, 4'hF, 32'h0,        32'h0BAD_F00D, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0BAD_F00D);
        send("ld_h_hi",  0, 2'd1, 32'h0000_8002, 32'h0,       0, 32'h0000_8000, 4'hC, 32'h0,        32'h8001_0000, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0000_8001);
        send("ld_b_hi",  0, 2'd0, 32'h0000_9003, 32'h0,       0, 32'h0000_9000, 4'h8, 32'h0,        32'hFF00_0000, 0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0000_00FF);

        // Split load stalled three cycles in FIRST, then reset while SECOND waits.
        @(negedge clk);
        chk("abort_ready", req_ready, 1'b1);
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_A003;
        aq.push_back('{a: 32'h0000_A000, be: 4'h8, wr: 1'b0, wd: 32'h0, rd: 32'h1100_0000});
        aq.push_back('{a: 32'h0000_A004, be: 4'h7, wr: 1'b0, wd: 32'h0, rd: 32'h0044_3322});
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        chk("abort_second_valid", mem_valid, 1'b1);
        chk("abort_second_addr", mem_addr, 32'h0000_A004);
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_valid", mem_valid, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_byteen", mem_byteen, 4'h0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_acc_left", aq.size(), 1);
        aq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1 chk("abort_req_ready", req_ready, 1'b1);
        repeat (6) @(negedge clk);
        #2 chk("abort_idle_valid", mem_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
